// File: rtl/result_tx_fifo.sv
// ---------------------------------------------------------------------------
// result_tx_fifo
//   Buffers ALU result bytes in a small circular FIFO and hands them, one at a
//   time and strictly in write order, to a UART transmitter through a
//   start/done handshake.
//
//   Optional feature (compile-time macro RESULT_TX_OVF_EN):
//     defined     -> o_overflow is a sticky flag set when a write is dropped
//                    because the FIFO is full and no pop happens that cycle.
//     not defined -> no overflow logic, o_overflow is tied to 0.
//   Dropping behaviour is identical in both builds.
// ---------------------------------------------------------------------------
module result_tx_fifo #(
  parameter int NB_DATA = 8,
  parameter int NB_ADDR = 2
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_wr,
  input  logic [NB_DATA-1:0] i_data,
  input  logic               i_tx_done,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_overflow
);

  localparam int DEPTH_N = 2 ** NB_ADDR;
  // Count value meaning "full": a one in the MSB with all lower bits zero.
  localparam logic [NB_ADDR:0] COUNT_FULL = {1'b1, {NB_ADDR{1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [NB_DATA-1:0] mem_q [DEPTH_N];
  logic [NB_ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [NB_ADDR-1:0] rd_ptr_q, rd_ptr_d;
  logic [NB_ADDR:0]   count_q,  count_d;
  logic               empty_q,  empty_d;
  logic               full_q,   full_d;
  logic               tx_start_q, tx_start_d;
  logic [NB_DATA-1:0] tx_data_q,  tx_data_d;

  logic pop;
  logic wr_en;

  // A write is taken when there is room, or when the FSM frees a slot in the
  // same cycle; otherwise the byte is dropped and the FIFO is left untouched.
  assign wr_en = i_wr && !i_reset && (!full_q || pop);

  // ------------------------------------------------------------------------
  // FSM: state register
  // NOTE: sequential state is assigned with non-blocking (<=) so every flop
  // samples pre-edge values; combinational blocks use blocking (=).
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM: next-state logic
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:      if (!empty_q)  state_d = ST_SEND;
      ST_SEND:                     state_d = ST_WAIT_DONE;
      ST_WAIT_DONE: if (i_tx_done) state_d = ST_IDLE;
      default:                     state_d = ST_IDLE;
    endcase
  end

  // FSM: output logic -- pop the head and launch a frame from IDLE only.
  // i_tx_done seen in IDLE or SEND has no effect here.
  always_comb begin
    pop        = 1'b0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    if (state_q == ST_IDLE && !empty_q) begin
      pop        = 1'b1;
      tx_start_d = 1'b1;
      tx_data_d  = mem_q[rd_ptr_q];
    end
  end

  // ------------------------------------------------------------------------
  // FIFO next-state: pointers wrap naturally at 2**NB_ADDR; a simultaneous
  // write and pop leaves the occupancy unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Full tracks the post-edge occupancy so a write arriving right after the
    // last free slot is taken is already rejected. Empty follows the
    // registered count, which sets the two-edge write-to-start latency.
    full_d  = (count_d == COUNT_FULL);
    empty_d = (count_q == '0);
  end

  // FIFO control and transmit registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  // FIFO storage
  // NOTE: the storage array has no reset; the pointers and count define
  // which entries are valid, so stale contents are never read.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= i_data;
  end

  // ------------------------------------------------------------------------
`ifdef RESULT_TX_OVF_EN
  logic ovf_q;

  // Sticky overflow: set by any rejected write, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_reset)            ovf_q <= 1'b0;
    else if (i_wr && !wr_en) ovf_q <= 1'b1;
  end

  assign o_overflow = ovf_q;
`else
  assign o_overflow = 1'b0;
`endif

  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_full     = full_q;
  assign o_empty    = empty_q;

endmodule

// File: tb/tb_result_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_result_tx_fifo
//   Directed bench for result_tx_fifo: reset state, single byte latency,
//   burst ordering, full/drop, write+pop at full, and reset mid-transfer.
//   Inputs change and outputs are checked on the falling edge; a monitor
//   logs every transmit start 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_result_tx_fifo;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_wr;
  logic [7:0] i_data;
  logic       i_tx_done;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       o_full;
  logic       o_empty;
  logic       o_overflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] start_q [$];
  logic       prev_start = 1'b0;
  logic       exp_ovf;
  int         base;

  result_tx_fifo #(.NB_DATA(8), .NB_ADDR(2)) dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_wr       (i_wr),
    .i_data     (i_data),
    .i_tx_done  (i_tx_done),
    .o_tx_start (o_tx_start),
    .o_tx_data  (o_tx_data),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_overflow (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic pulse_done();
    i_tx_done = 1'b1;
    step(1);
    i_tx_done = 1'b0;
  endtask

  // Start monitor: records each launched byte and checks the pulse is one cycle.
  always @(posedge i_clk) begin
    #1;
    if (o_tx_start) begin
      check("start_one_cycle", {31'd0, prev_start}, 32'd0);
      start_q.push_back(o_tx_data);
    end
    prev_start = o_tx_start;
  end

  initial begin
`ifdef RESULT_TX_OVF_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif
    i_reset   = 1'b1;
    i_wr      = 1'b0;
    i_data    = 8'h00;
    i_tx_done = 1'b0;

    // 1: reset held for two edges
    step(2);
    check("rst_empty",    {31'd0, o_empty},    32'd1);
    check("rst_full",     {31'd0, o_full},     32'd0);
    check("rst_tx_start", {31'd0, o_tx_start}, 32'd0);
    check("rst_tx_data",  {24'd0, o_tx_data},  32'h00);
    check("rst_overflow", {31'd0, o_overflow}, 32'd0);
    i_reset = 1'b0;
    step(3);

    // 2: single byte, exact write-to-start latency
    base   = start_q.size();
    i_wr   = 1'b1;
    i_data = 8'h2A;
    step(1);                       // edge N has written the byte
    i_wr   = 1'b0;
    check("t2_start_after_n",   {31'd0, o_tx_start}, 32'd0);
    step(1);                       // after N+1
    check("t2_empty_after_n1",  {31'd0, o_empty},    32'd0);
    check("t2_start_after_n1",  {31'd0, o_tx_start}, 32'd0);
    step(1);                       // after N+2
    check("t2_start_after_n2",  {31'd0, o_tx_start}, 32'd1);
    check("t2_data_after_n2",   {24'd0, o_tx_data},  32'h2A);
    step(1);
    check("t2_start_dropped",   {31'd0, o_tx_start}, 32'd0);
    check("t2_data_held",       {24'd0, o_tx_data},  32'h2A);
    step(7);
    pulse_done();
    step(5);
    check("t2_empty_end",  {31'd0, o_empty},  32'd1);
    check("t2_start_count", start_q.size(),   base + 1);

    // 3: burst of three, one start per done, in order
    base = start_q.size();
    i_wr = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      i_data = 8'(i);
      step(1);
    end
    i_wr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step(18);
      check("t3_starts_before_done", start_q.size(), base + k + 1);
      pulse_done();
      step(1);
    end
    step(5);
    check("t3_start_count", start_q.size(), base + 3);
    for (int i = 0; i < 3; i++)
      check("t3_order", {24'd0, start_q[base + i]}, i + 1);
    check("t3_empty_end", {31'd0, o_empty}, 32'd1);

    // 4: one in flight, four buffered, sixth byte dropped
    base = start_q.size();
    i_wr = 1'b1;
    for (int i = 0; i < 6; i++) begin
      i_data = 8'h10 + 8'(i);
      step(1);
    end
    i_wr = 1'b0;
    step(2);
    check("t4_full",          {31'd0, o_full},     32'd1);
    check("t4_not_empty",     {31'd0, o_empty},    32'd0);
    check("t4_overflow",      {31'd0, o_overflow}, {31'd0, exp_ovf});
    check("t4_first_started", start_q.size(),      base + 1);
    check("t4_first_data",    {24'd0, o_tx_data},  32'h10);
    for (int k = 0; k < 5; k++) begin
      pulse_done();
      step(8);
    end
    check("t4_start_count", start_q.size(), base + 5);
    for (int i = 0; i < 5; i++)
      check("t4_order", {24'd0, start_q[base + i]}, 32'h10 + i);
    check("t4_empty_end",    {31'd0, o_empty},    32'd1);
    check("t4_full_end",     {31'd0, o_full},     32'd0);
    check("t4_ovf_sticky",   {31'd0, o_overflow}, {31'd0, exp_ovf});

    // clear the sticky flag before the next case
    i_reset = 1'b1;
    step(2);
    i_reset = 1'b0;
    check("rst2_overflow", {31'd0, o_overflow}, 32'd0);
    step(2);

    // 5: full FIFO, write lands on the same edge as the pop
    base = start_q.size();
    i_wr = 1'b1;
    for (int i = 0; i < 5; i++) begin
      i_data = 8'h20 + 8'(i);
      step(1);
    end
    i_wr = 1'b0;
    step(3);
    check("t5_full_before", {31'd0, o_full}, 32'd1);
    check("t5_one_started", start_q.size(),  base + 1);
    pulse_done();                  // edge D: back to IDLE
    i_wr   = 1'b1;                 // written at edge D+1, the pop edge
    i_data = 8'hAA;
    step(1);
    i_wr   = 1'b0;
    check("t5_start_at_pop", {31'd0, o_tx_start}, 32'd1);
    check("t5_data_at_pop",  {24'd0, o_tx_data},  32'h21);
    check("t5_full_at_pop",  {31'd0, o_full},     32'd1);
    step(1);
    check("t5_full_after",   {31'd0, o_full},     32'd1);
    check("t5_no_overflow",  {31'd0, o_overflow}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      step(8);
      pulse_done();
    end
    step(6);
    check("t5_start_count", start_q.size(), base + 6);
    for (int i = 0; i < 5; i++)
      check("t5_order", {24'd0, start_q[base + i]}, 32'h20 + i);
    check("t5_aa_sent",       {24'd0, start_q[base + 5]}, 32'hAA);
    check("t5_empty_end",     {31'd0, o_empty},    32'd1);
    check("t5_overflow_end",  {31'd0, o_overflow}, 32'd0);

    // 6: reset while waiting for done with two queued
    base = start_q.size();
    i_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_data = 8'h30 + 8'(i);
      step(1);
    end
    i_wr = 1'b0;
    step(4);
    check("t6_in_flight", start_q.size(), base + 1);
    i_reset = 1'b1;
    step(1);
    i_reset = 1'b0;
    pulse_done();                  // stale frame-complete arrives in IDLE
    check("t6_empty_after_rst", {31'd0, o_empty},    32'd1);
    check("t6_full_after_rst",  {31'd0, o_full},     32'd0);
    check("t6_data_after_rst",  {24'd0, o_tx_data},  32'h00);
    step(10);
    check("t6_no_start", start_q.size(),      base + 1);
    check("t6_idle_empty", {31'd0, o_empty},  32'd1);
    i_wr   = 1'b1;
    i_data = 8'h55;
    step(1);
    i_wr   = 1'b0;
    step(3);
    check("t6_new_start", start_q.size(), base + 2);
    check("t6_new_data",  {24'd0, start_q[base + 1]}, 32'h55);
    pulse_done();
    step(4);
    check("t6_empty_end", {31'd0, o_empty}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
